ddma_tx_engine: RTL and testbench

- Responder end of the DMA command interface: the engine behind the DDMA modport.
- Accepts a command (word address, byte count, start strobe) from the task/command driver and reads the buffer from local memory through a 1-cycle-latency read port.
- Emits the buffer as a NoC packet: one header flit followed by payload flits, with valid/ready flow control.
- Reports progress on status_out and raises sticky interrupts on irq_out.

---
 rtl/ddma_pkg.sv | 24 ++
 rtl/ddma_tx_engine_if.sv | 37 +++
 rtl/ddma_skid_fifo.sv | 55 +++++
 rtl/ddma_tx_engine.sv | 187 ++++++++++++++++++
 tb/tb_ddma_tx_engine.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ddma_pkg.sv
// Shared types and constants for the DMA transmit engine.
// Imported by the interface, the skid FIFO and the engine top.
package ddma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        STREAM,
        DRAIN
    } state_e;

    localparam int BUSY     = 0;
    localparam int DONE     = 1;
    localparam int ERROR    = 2;
    localparam int HDR_SENT = 3;

    localparam int IRQ_DONE = 0;
    localparam int IRQ_ERR  = 1;

    localparam int HDR_ADDR_W = 16;
    localparam int HDR_LEN_W  = 16;
    localparam int MAX_WORDS  = 65535;

endpackage

// File: rtl/ddma_tx_engine_if.sv
// Command, memory read port and NoC flit bundle of the DMA tx engine.
// master = command driver / memory / NoC side, slave = the engine.
interface ddma_tx_engine_if
    import ddma_pkg::*;
#(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int FLIT_WIDTH       = 32
);
    logic [MEMORY_BUS_WIDTH-3:0] addr_in;
    logic [MEMORY_BUS_WIDTH-3:0] nbytes_in;
    logic                        cmd_in;
    logic [4:0]                  status_out;
    logic [4:0]                  irq_out;
    logic [MEMORY_BUS_WIDTH-3:0] mem_addr_out;
    logic                        mem_rd_en_out;
    logic [MEMORY_BUS_WIDTH-1:0] mem_data_in;
    logic [FLIT_WIDTH-1:0]       flit_out;
    logic                        flit_valid_out;
    logic                        flit_ready_in;

    modport master (
        output addr_in, nbytes_in, cmd_in,
        output mem_data_in, flit_ready_in,
        input  status_out, irq_out,
        input  mem_addr_out, mem_rd_en_out,
        input  flit_out, flit_valid_out
    );

    modport slave (
        input  addr_in, nbytes_in, cmd_in,
        input  mem_data_in, flit_ready_in,
        output status_out, irq_out,
        output mem_addr_out, mem_rd_en_out,
        output flit_out, flit_valid_out
    );

endinterface

// File: rtl/ddma_skid_fifo.sv
// Two-entry flit buffer between the memory read port and the NoC.
// Push while full is honoured only when a pop happens in the same cycle.
module ddma_skid_fifo
    import ddma_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wp_q;
    logic         rp_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    assign cnt_d   = cnt_q + 2'(do_push) - 2'(do_pop);

    assign head_o  = mem_q[rp_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;

    // Storage, pointers and occupancy update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wp_q] <= data_i;
                wp_q        <= ~wp_q;
            end
            if (do_pop) begin
                rp_q <= ~rp_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ddma_tx_engine.sv
// DMA transmit engine: reads a buffer from local memory and sends it
// as one header flit plus payload flits with valid/ready flow control.
module ddma_tx_engine
    import ddma_pkg::*;
#(
    parameter int MEMORY_BUS_WIDTH   = 32,
    parameter int FLIT_WIDTH         = 32,
    parameter int INTERLEAVING_GRAIN = 3,
    parameter int ADDRESS            = 0
) (
    input logic             clock,
    input logic             reset,
    ddma_tx_engine_if.slave bus
);
    localparam int AW = MEMORY_BUS_WIDTH - 2;
    localparam int GW = INTERLEAVING_GRAIN + 1;
    localparam logic [GW-1:0] GAP_AT = GW'(2 ** INTERLEAVING_GRAIN);
    localparam logic [HDR_ADDR_W-1:0] NODE = HDR_ADDR_W'(ADDRESS);

    if (FLIT_WIDTH != MEMORY_BUS_WIDTH) begin : g_width_chk
        $error("ddma_tx_engine: FLIT_WIDTH must equal MEMORY_BUS_WIDTH");
    end

    state_e                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [HDR_LEN_W-1:0]   wcnt_q, wcnt_d;
    logic [HDR_LEN_W-1:0]   rem_q, rem_d;
    logic [HDR_LEN_W-1:0]   left_q, left_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [3:0]             sts_q, sts_d;
    logic [1:0]             irq_q, irq_d;
    logic                   inflt_q;

    logic [AW:0]            wcnt_full;
    logic                   cmd_bad;
    logic [31:0]            hdr32;
    logic                   rd;
    logic                   pop;
    logic                   valid;
    logic                   gap;
    logic [2:0]             occ;
    logic [FLIT_WIDTH-1:0]  flit;

    logic [FLIT_WIDTH-1:0]  f_head;
    logic                   f_full;
    logic                   f_empty;
    logic [1:0]             f_cnt;

    // One extra bit keeps the round-up from overflowing near 2^AW bytes.
    assign wcnt_full = ({1'b0, bus.nbytes_in} + (AW+1)'(3)) >> 2;
    assign cmd_bad   = (bus.nbytes_in == '0)
                     || (wcnt_full > (AW+1)'(MAX_WORDS));
    assign hdr32     = {NODE, wcnt_q};

    ddma_skid_fifo #(
        .W (FLIT_WIDTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (inflt_q),
        .pop_i   (pop),
        .data_i  (bus.mem_data_in),
        .head_o  (f_head),
        .full_o  (f_full),
        .empty_o (f_empty),
        .count_o (f_cnt)
    );

    // Next-state, read issue, flit output and status/irq update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        rem_d   = rem_q;
        left_d  = left_q;
        gap_d   = gap_q;
        sts_d   = sts_q;
        irq_d   = irq_q;
        rd      = 1'b0;
        pop     = 1'b0;
        valid   = 1'b0;
        gap     = 1'b0;
        occ     = 3'd0;
        flit    = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_in) begin
                    if (cmd_bad) begin
                        sts_d[ERROR]   = 1'b1;
                        irq_d[IRQ_ERR] = 1'b1;
                    end else begin
                        addr_d      = bus.addr_in;
                        wcnt_d      = wcnt_full[HDR_LEN_W-1:0];
                        rem_d       = wcnt_full[HDR_LEN_W-1:0];
                        left_d      = wcnt_full[HDR_LEN_W-1:0];
                        gap_d       = '0;
                        sts_d       = '0;
                        sts_d[BUSY] = 1'b1;
                        irq_d       = '0;
                        state_d     = HDR;
                    end
                end
            end
            HDR: begin
                valid = 1'b1;
                flit  = FLIT_WIDTH'(hdr32);
                if (bus.flit_ready_in) begin
                    sts_d[HDR_SENT] = 1'b1;
                    state_d         = STREAM;
                end
            end
            STREAM: begin
                valid = !f_empty;
                flit  = f_head;
                pop   = valid && bus.flit_ready_in;
                // Slot freed by a same-cycle pop counts as free space.
                occ   = 3'(f_cnt) + 3'(inflt_q) - 3'(pop);
                gap   = (gap_q == GAP_AT);
                rd    = (rem_q != '0) && (occ < 3'd2)
                      && (!f_full || pop) && !gap;
                gap_d = (rd && !gap) ? gap_q + GW'(1) : '0;
                if (rd) begin
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - HDR_LEN_W'(1);
                    if (rem_q == HDR_LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                valid = !f_empty;
                flit  = f_head;
                pop   = valid && bus.flit_ready_in;
                if (pop && (left_q == HDR_LEN_W'(1))) begin
                    sts_d[BUSY]     = 1'b0;
                    sts_d[DONE]     = 1'b1;
                    irq_d[IRQ_DONE] = 1'b1;
                    state_d         = IDLE;
                end
            end
        endcase

        if (pop) begin
            left_d = left_q - HDR_LEN_W'(1);
        end

        // A command while busy is refused; the running transfer goes on.
        if (bus.cmd_in && (state_q != IDLE)) begin
            sts_d[ERROR]   = 1'b1;
            irq_d[IRQ_ERR] = 1'b1;
        end
    end

    // State and datapath registers; reset drops any read in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            rem_q   <= '0;
            left_q  <= '0;
            gap_q   <= '0;
            sts_q   <= '0;
            irq_q   <= '0;
            inflt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            rem_q   <= rem_d;
            left_q  <= left_d;
            gap_q   <= gap_d;
            sts_q   <= sts_d;
            irq_q   <= irq_d;
            inflt_q <= rd;
        end
    end

    assign bus.status_out     = {1'b0, sts_q};
    assign bus.irq_out        = {3'b000, irq_q};
    assign bus.mem_addr_out   = addr_q;
    assign bus.mem_rd_en_out  = rd;
    assign bus.flit_out       = flit;
    assign bus.flit_valid_out = valid;

endmodule

// File: tb/tb_ddma_tx_engine.sv
// Directed bench for ddma_tx_engine: memory model returns {2'b11, addr}
// one cycle after each read; monitor logs handshaken flits and reads.
module tb_ddma_tx_engine;
    logic clock;
    logic reset;

    ddma_tx_engine_if #(
        .MEMORY_BUS_WIDTH (32),
        .FLIT_WIDTH       (32)
    ) bus ();

    ddma_tx_engine #(
        .MEMORY_BUS_WIDTH   (32),
        .FLIT_WIDTH         (32),
        .INTERLEAVING_GRAIN (3),
        .ADDRESS            (0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] flits [$];
    logic [29:0] raddr [$];
    int          ftime [$];
    int          rtime [$];
    logic        stalled = 1'b0;
    logic [31:0] held = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clock) begin
        if (bus.mem_rd_en_out)
            bus.mem_data_in <= {2'b11, bus.mem_addr_out};
    end

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", 32'(bus.flit_valid_out), 32'd1);
                chk("stall_data", bus.flit_out, held);
            end
            if (bus.flit_valid_out && bus.flit_ready_in) begin
                flits.push_back(bus.flit_out);
                ftime.push_back(cyc);
            end
            if (bus.mem_rd_en_out) begin
                raddr.push_back(bus.mem_addr_out);
                rtime.push_back(cyc);
            end
            stalled = bus.flit_valid_out && !bus.flit_ready_in;
            held    = bus.flit_out;
        end
    end

    task automatic start_cmd(input logic [29:0] a, input logic [29:0] nb);
        @(negedge clock);
        flits.delete();
        raddr.delete();
        ftime.delete();
        rtime.delete();
        bus.addr_in   = a;
        bus.nbytes_in = nb;
        bus.cmd_in    = 1'b1;
        @(negedge clock);
        bus.cmd_in    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.status_out[1] !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(n < 300), 32'd1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_status"}, 32'(bus.status_out), 32'd0);
        chk({tag, "_irq"}, 32'(bus.irq_out), 32'd0);
        chk({tag, "_rden"}, 32'(bus.mem_rd_en_out), 32'd0);
        chk({tag, "_valid"}, 32'(bus.flit_valid_out), 32'd0);
        chk({tag, "_maddr"}, 32'(bus.mem_addr_out), 32'd0);
        chk({tag, "_flit"}, bus.flit_out, 32'd0);
    endtask

    initial begin
        int n;
        reset             = 1'b1;
        bus.addr_in       = '0;
        bus.nbytes_in     = '0;
        bus.cmd_in        = 1'b0;
        bus.flit_ready_in = 1'b1;

        @(negedge clock);
        chk_zero_outputs("reset");
        reset = 1'b0;

        // Basic 3-word transfer
        start_cmd(30'h10, 30'd12);
        chk("t1_hdr_valid", 32'(bus.flit_valid_out), 32'd1);
        chk("t1_hdr_flit", bus.flit_out, 32'h0000_0003);
        chk("t1_busy", 32'(bus.status_out), 32'b00001);
        wait_done("t1_done");
        chk("t1_count", 32'(flits.size()), 32'd4);
        if (flits.size() == 4) begin
            chk("t1_f0", flits[0], 32'h0000_0003);
            chk("t1_f1", flits[1], 32'hC000_0010);
            chk("t1_f2", flits[2], 32'hC000_0011);
            chk("t1_f3", flits[3], 32'hC000_0012);
            chk("t1_b2b", 32'(ftime[3] - ftime[1]), 32'd2);
        end
        chk("t1_status", 32'(bus.status_out), 32'b01010);
        chk("t1_irq", 32'(bus.irq_out), 32'b00001);

        // Rounding (37 bytes -> 10 words) and interleave gap
        start_cmd(30'h100, 30'd37);
        wait_done("t2_done");
        chk("t2_count", 32'(flits.size()), 32'd11);
        chk("t2_reads", 32'(rtime.size()), 32'd10);
        if (flits.size() == 11 && rtime.size() == 10) begin
            chk("t2_hdr", flits[0], 32'h0000_000A);
            for (int i = 1; i < 11; i++)
                chk("t2_data", flits[i], 32'hC000_0100 + 32'(i - 1));
            chk("t2_run8", 32'(rtime[7] - rtime[0]), 32'd7);
            chk("t2_gap", 32'(rtime[8] - rtime[7]), 32'd2);
            chk("t2_after", 32'(rtime[9] - rtime[8]), 32'd1);
        end

        // Backpressure: ready toggles every cycle
        start_cmd(30'h20, 30'd16);
        n = 0;
        while (bus.status_out[1] !== 1'b1 && n < 300) begin
            @(negedge clock);
            bus.flit_ready_in = ~bus.flit_ready_in;
            n++;
        end
        chk("t3_done", 32'(n < 300), 32'd1);
        bus.flit_ready_in = 1'b1;
        chk("t3_count", 32'(flits.size()), 32'd5);
        if (flits.size() == 5) begin
            chk("t3_hdr", flits[0], 32'h0000_0004);
            for (int i = 1; i < 5; i++)
                chk("t3_data", flits[i], 32'hC000_0020 + 32'(i - 1));
        end

        // Zero-length command after a clean reset
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        start_cmd(30'h30, 30'd0);
        chk("t4_status", 32'(bus.status_out), 32'b00100);
        chk("t4_irq", 32'(bus.irq_out), 32'b00010);
        chk("t4_valid", 32'(bus.flit_valid_out), 32'd0);
        repeat (4) @(negedge clock);
        chk("t4_noflits", 32'(flits.size()), 32'd0);

        // Command while busy
        start_cmd(30'h40, 30'd16);
        chk("t4b_errclr", 32'(bus.status_out), 32'b00001);
        repeat (2) @(negedge clock);
        bus.nbytes_in = 30'd8;
        bus.cmd_in    = 1'b1;
        @(negedge clock);
        bus.cmd_in    = 1'b0;
        chk("t4b_err", 32'(bus.status_out[2]), 32'd1);
        chk("t4b_busy", 32'(bus.status_out[0]), 32'd1);
        wait_done("t4b_done");
        chk("t4b_count", 32'(flits.size()), 32'd5);
        if (flits.size() == 5) begin
            chk("t4b_hdr", flits[0], 32'h0000_0004);
            chk("t4b_last", flits[4], 32'hC000_0043);
        end
        chk("t4b_status", 32'(bus.status_out), 32'b01110);
        chk("t4b_irq", 32'(bus.irq_out), 32'b00011);

        // Read address wraps at 2^30
        start_cmd(30'h3FFF_FFFE, 30'd16);
        wait_done("t5_done");
        chk("t5_reads", 32'(raddr.size()), 32'd4);
        if (raddr.size() == 4) begin
            chk("t5_a0", 32'(raddr[0]), 32'h3FFF_FFFE);
            chk("t5_a1", 32'(raddr[1]), 32'h3FFF_FFFF);
            chk("t5_a2", 32'(raddr[2]), 32'h0000_0000);
            chk("t5_a3", 32'(raddr[3]), 32'h0000_0001);
        end
        if (flits.size() == 5) begin
            chk("t5_d2", flits[3], 32'hC000_0000);
        end

        // Reset in the middle of a stream
        start_cmd(30'h80, 30'd32);
        n = 0;
        while (flits.size() < 3 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("t6_reach", 32'(n < 100), 32'd1);
        chk("t6_busy", 32'(bus.status_out[0]), 32'd1);
        reset = 1'b1;
        #1;
        chk_zero_outputs("t6_rst");
        @(negedge clock);
        chk_zero_outputs("t6_hold");
        reset = 1'b0;
        start_cmd(30'h5, 30'd4);
        wait_done("t6_done");
        chk("t6_count", 32'(flits.size()), 32'd2);
        if (flits.size() == 2) begin
            chk("t6_hdr", flits[0], 32'h0000_0001);
            chk("t6_data", flits[1], 32'hC000_0005);
        end
        chk("t6_irq", 32'(bus.irq_out), 32'b00001);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
